// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller: arbitrates memory-wait, branch-redirect and
// load-use requests into PC / IF/ID / ID/EX / back-end register controls, and
// keeps saturating performance counters.
module pipeline_stall_controller #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hazard_stall,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             clear_counters,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] memwait_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic {RUN, MEM_WAIT} state_t;
  typedef enum logic [1:0] {NORMAL, REDIRECT, BUBBLE, FREEZE} action_t;

  state_t            state, stateNext;
  action_t           act;
  logic [WAIT_W-1:0] waitCnt, waitNext;

  // Arbitration: an unfinished memory access freezes everything; otherwise
  // redirect beats bubble because the stalled instruction is flushed anyway.
  always_comb begin
    act       = NORMAL;
    stateNext = RUN;
    if ((state == RUN && dmem_req && !dmem_ready) || (state == MEM_WAIT && !dmem_ready)) begin
      act       = FREEZE;
      stateNext = MEM_WAIT;
    end else if (branch_taken) begin
      act = REDIRECT;
    end else if (hazard_stall) begin
      act = BUBBLE;
    end
  end

  // Decode the chosen action into register controls; reset forces a safe NOP fill.
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_hold    = 1'b0;
    if (reset) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      unique case (act)
        NORMAL:   begin pc_write = 1'b1; if_id_write = 1'b1; end
        REDIRECT: begin
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end
        BUBBLE:   id_ex_bubble = 1'b1;
        FREEZE:   pipe_hold    = 1'b1;
        default:  ;
      endcase
    end
  end

  // Wait length after this cycle: restarts at 1 on entry, saturates at the timeout.
  always_comb begin
    waitNext = waitCnt;
    if (act == FREEZE) begin
      if (state == RUN)           waitNext = WAIT_W'(1);
      else if (waitCnt != WAIT_MAX) waitNext = waitCnt + WAIT_W'(1);
    end
  end

  // State and wait-length registers; clear_counters leaves wait tracking alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      waitCnt <= '0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitNext;
    end
  end

  // Sticky timeout flag and saturating event counters; clear wins over any update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      memwait_cnt <= '0;
    end else if (clear_counters) begin
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      memwait_cnt <= '0;
    end else begin
      if (act == FREEZE && waitNext == WAIT_MAX) mem_timeout <= 1'b1;
      if (act == BUBBLE   && stall_cnt   != CNT_MAX) stall_cnt   <= stall_cnt + 1'b1;
      if (act == REDIRECT && flush_cnt   != CNT_MAX) flush_cnt   <= flush_cnt + 1'b1;
      if (act == FREEZE   && memwait_cnt != CNT_MAX) memwait_cnt <= memwait_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: two instances (16-bit and 2-bit counters,
// both timing out after 4 wait cycles) driven in lockstep and scored against a
// cycle model through an expectation queue, plus directed spot checks.
module tb_pipeline_stall_controller;

  logic clk = 1'b0;
  logic reset, hazardStall, branchTaken, dmemReq, dmemReady, clearCounters;

  logic pcW [2], ifW [2], ifF [2], idB [2], hold [2], tmo [2];
  logic [15:0] sCnt0, fCnt0, mCnt0;
  logic [1:0]  sCnt1, fCnt1, mCnt1;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.CNT_W(16), .MEM_TIMEOUT(4)) dutWide (
    .clk(clk), .reset(reset), .hazard_stall(hazardStall), .branch_taken(branchTaken),
    .dmem_req(dmemReq), .dmem_ready(dmemReady), .clear_counters(clearCounters),
    .pc_write(pcW[0]), .if_id_write(ifW[0]), .if_id_flush(ifF[0]), .id_ex_bubble(idB[0]),
    .pipe_hold(hold[0]), .mem_timeout(tmo[0]),
    .stall_cnt(sCnt0), .flush_cnt(fCnt0), .memwait_cnt(mCnt0));

  pipeline_stall_controller #(.CNT_W(2), .MEM_TIMEOUT(4)) dutNarrow (
    .clk(clk), .reset(reset), .hazard_stall(hazardStall), .branch_taken(branchTaken),
    .dmem_req(dmemReq), .dmem_ready(dmemReady), .clear_counters(clearCounters),
    .pc_write(pcW[1]), .if_id_write(ifW[1]), .if_id_flush(ifF[1]), .id_ex_bubble(idB[1]),
    .pipe_hold(hold[1]), .mem_timeout(tmo[1]),
    .stall_cnt(sCnt1), .flush_cnt(fCnt1), .memwait_cnt(mCnt1));

  typedef struct {
    logic [4:0]  ctl;      // {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold}
    logic        tmo;
    logic [15:0] s, f, m;
  } exp_t;

  exp_t expQ [2][$];

  int nChk = 0, nPass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChk++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model state per instance.
  logic        mWait [2];
  int          mWaitLen [2];
  logic        mTmo [2];
  int          mS [2], mF [2], mM [2];
  int          satMax [2] = '{65535, 3};
  int          mAct [2];   // 0 normal, 1 redirect, 2 bubble, 3 freeze

  function automatic logic [4:0] ctlOf(input int a, input logic r);
    if (r) return 5'b00110;
    case (a)
      1:       return 5'b11110;
      2:       return 5'b00010;
      3:       return 5'b00001;
      default: return 5'b11000;
    endcase
  endfunction

  function automatic int satInc(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  // Drive one cycle: inputs at negedge, expectations queued, outputs scored
  // mid-low-phase, model advanced at the rising edge.
  task automatic cycle(input logic r, input logic hs, input logic bt,
                       input logic rq, input logic rd, input logic clr);
    exp_t e, got;
    @(negedge clk);
    reset = r; hazardStall = hs; branchTaken = bt;
    dmemReq = rq; dmemReady = rd; clearCounters = clr;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        mWait[k] = 1'b0; mWaitLen[k] = 0; mTmo[k] = 1'b0;
        mS[k] = 0; mF[k] = 0; mM[k] = 0;
      end
      if ((!mWait[k] && rq && !rd) || (mWait[k] && !rd)) mAct[k] = 3;
      else if (bt) mAct[k] = 1;
      else if (hs) mAct[k] = 2;
      else mAct[k] = 0;
      e.ctl = ctlOf(mAct[k], r);
      e.tmo = mTmo[k];
      e.s = 16'(mS[k]); e.f = 16'(mF[k]); e.m = 16'(mM[k]);
      expQ[k].push_back(e);
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      got.ctl = {pcW[k], ifW[k], ifF[k], idB[k], hold[k]};
      got.tmo = tmo[k];
      got.s = (k == 0) ? sCnt0 : 16'(sCnt1);
      got.f = (k == 0) ? fCnt0 : 16'(fCnt1);
      got.m = (k == 0) ? mCnt0 : 16'(mCnt1);
      if (expQ[k].size() == 0) begin
        chk($sformatf("queue_empty[%0d]", k), 32'd0, 32'd1);
      end else begin
        e = expQ[k].pop_front();
        chk($sformatf("ctl[%0d]", k), 32'(got.ctl), 32'(e.ctl));
        chk($sformatf("mem_timeout[%0d]", k), 32'(got.tmo), 32'(e.tmo));
        chk($sformatf("stall_cnt[%0d]", k), 32'(got.s), 32'(e.s));
        chk($sformatf("flush_cnt[%0d]", k), 32'(got.f), 32'(e.f));
        chk($sformatf("memwait_cnt[%0d]", k), 32'(got.m), 32'(e.m));
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r) continue;
      if (mAct[k] == 3) begin
        mWaitLen[k] = mWait[k] ? ((mWaitLen[k] >= 4) ? 4 : mWaitLen[k] + 1) : 1;
      end
      if (clr) begin
        mTmo[k] = 1'b0; mS[k] = 0; mF[k] = 0; mM[k] = 0;
      end else begin
        if (mAct[k] == 3 && mWaitLen[k] == 4) mTmo[k] = 1'b1;
        if (mAct[k] == 2) mS[k] = satInc(mS[k], satMax[k]);
        if (mAct[k] == 1) mF[k] = satInc(mF[k], satMax[k]);
        if (mAct[k] == 3) mM[k] = satInc(mM[k], satMax[k]);
      end
      mWait[k] = (mAct[k] == 3);
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; hazardStall = 1'b0; branchTaken = 1'b0;
    dmemReq = 1'b0; dmemReady = 1'b0; clearCounters = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mWait[k] = 1'b0; mWaitLen[k] = 0; mTmo[k] = 1'b0;
      mS[k] = 0; mF[k] = 0; mM[k] = 0; mAct[k] = 0;
    end

    // Reset held 3 cycles, with requests active to prove the override.
    cycle(1, 1, 0, 1, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("rst_pc_write", 32'(pcW[0]), 32'd0);
    chk("rst_flush", 32'(ifF[0]), 32'd1);
    cycle(0, 0, 0, 0, 0, 0);
    chk("post_rst_cnt", 32'(sCnt0 | fCnt0 | mCnt0), 32'd0);

    // Load-use bubble.
    cycle(0, 1, 0, 0, 0, 0);
    chk("loaduse_stall_cnt", 32'(sCnt0), 32'd1);
    cycle(0, 0, 0, 0, 1, 0);   // stray dmem_ready ignored
    cycle(0, 0, 0, 0, 0, 1);

    // Branch and stall together.
    cycle(0, 1, 1, 0, 0, 0);
    chk("branch_flush_cnt", 32'(fCnt0), 32'd1);
    chk("branch_stall_cnt", 32'(sCnt0), 32'd0);

    // Four-cycle memory wait with a branch held; redirect on release.
    repeat (4) cycle(0, 0, 1, 1, 0, 0);
    chk("memwait_cnt4", 32'(mCnt0), 32'd4);
    cycle(0, 0, 1, 1, 1, 0);
    chk("release_flush_cnt", 32'(fCnt0), 32'd2);
    chk("release_memwait_cnt", 32'(mCnt0), 32'd4);
    cycle(0, 0, 0, 0, 0, 1);

    // Timeout after 4 wait cycles, wait continues, clear drops the flag.
    for (int i = 1; i <= 6; i++) begin
      cycle(0, 1, 0, 1, 0, 0);
      if (i == 3) chk("tmo_before", 32'(tmo[0]), 32'd0);
      if (i == 4) chk("tmo_at4", 32'(tmo[0]), 32'd1);
    end
    chk("still_frozen", 32'(hold[0]), 32'd1);
    cycle(0, 1, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 0, 1);
    chk("clr_tmo", 32'(tmo[0]), 32'd0);
    chk("clr_cnt", 32'(sCnt0 | fCnt0 | mCnt0), 32'd0);

    // Saturation in the narrow instance.
    repeat (5) cycle(0, 1, 0, 0, 0, 0);
    chk("sat_stall_cnt", 32'(sCnt1), 32'd3);
    chk("wide_stall_cnt", 32'(sCnt0), 32'd5);

    // Reset in the middle of a memory wait.
    repeat (2) cycle(0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("rst_wait_pc_write", 32'(pcW[0]), 32'd1);

    // Random traffic for broader coverage of the arbitration and counters.
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 99) == 0), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
    end

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
